serial_add_ctrl: RTL

Bit-serial adder controller that time-multiplexes one full-adder cell, built from two `half` instances plus an OR, across a WIDTH-bit operand pair, processing one bit per clock, LSB first. It accepts a start pulse, sequences the shared adder cell through WIDTH bit-slices, and presents a registered WIDTH-bit Sum and Carry with a one-cycle done pulse. It sits between a requester issuing add operations and the existing half-adder datapath, trading latency for area.

---
 rtl/serial_add_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller sharing one full-adder cell
// Optional signed-overflow output Ovf is enabled by defining SERIAL_ADD_OVF_EN.

module half (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             Ovf
`endif
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cy_q, cy_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic s0, c0, bit_s, c1, cout, last_bit;

  // Shared full-adder cell: LSBs of the operand shift registers plus running carry
  half u_ha0 (.a_i(opa_q[0]), .b_i(opb_q[0]), .s_o(s0),    .c_o(c0));
  half u_ha1 (.a_i(s0),       .b_i(cy_q),     .s_o(bit_s), .c_o(c1));
  assign cout     = c0 | c1;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cy_d    = cy_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          opa_d   = A;
          opb_d   = B;
          cy_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        acc_d = {bit_s, acc_q[WIDTH-1:1]};
        opa_d = {1'b0, opa_q[WIDTH-1:1]};
        opb_d = {1'b0, opb_q[WIDTH-1:1]};
        cy_d  = cout;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          sum_d   = acc_d;
          carry_d = cout;
`ifdef SERIAL_ADD_OVF_EN
          // cy_q is the carry into the MSB at this point
          ovf_d   = cy_q ^ cout;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Sum   = sum_q;
  assign Carry = carry_q;
`ifdef SERIAL_ADD_OVF_EN
  assign Ovf   = ovf_q;
`endif

endmodule
